// File: rtl/dtw_feeder_pkg.sv
// Shared types, default sizes and width helper for the DTW sample feeder.
// No logic, no latency, no flow control of its own.
// Imported by dtw_sync_fifo and dtw_sin_feeder.
package dtw_feeder_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_FRAME_LEN = 32;

    typedef enum logic [0:0] {
        STREAM    = 1'b0,
        WAIT_DONE = 1'b1
    } feeder_state_t;

    // Index width for a range of n entries; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dtw_sync_fifo.sv
// Generic single-clock show-ahead FIFO with synchronous flush.
// Latency: a word written at edge t is visible on rd_dat/!empty after edge t.
// Backpressure: push ignored while full, pop ignored while empty.
module dtw_sync_fifo
    import dtw_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [idx_bits(DEPTH):0] count
);

    localparam int AW = idx_bits(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!nrst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/dtw_sin_feeder.sv
// Frame-gated sample feeder for the DTW core; optional o_level via DTW_FEEDER_LEVEL_EN.
// Latency: word pushed into an empty FIFO at edge t is offered (o_valid) after edge t.
// Backpressure: o_ready drops when full; output stalls on i_ready=0 and between frames until i_frame_done.
module dtw_sin_feeder
    import dtw_feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_last,
    input  logic                     i_frame_done,
    input  logic                     i_flush,
    output logic [7:0]               o_frames
`ifdef DTW_FEEDER_LEVEL_EN
    ,
    output logic [idx_bits(DEPTH):0] o_level
`endif
);

    localparam int AW = idx_bits(DEPTH);
    localparam int CW = idx_bits(FRAME_LEN);

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    feeder_state_t state;

    assign o_ready = !full && nrst;
    assign o_valid = nrst && (state == STREAM) && !empty;
    assign o_last  = o_valid && (cnt == CW'(FRAME_LEN - 1));
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    dtw_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nrst   (nrst),
        .flush  (i_flush),
        .push   (push),
        .wr_dat (i_data),
        .pop    (pop),
        .rd_dat (o_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

`ifdef DTW_FEEDER_LEVEL_EN
    assign o_level = count;
`else
    logic level_unused;
    assign level_unused = ^count;
`endif

    // A done pulse only matters once the frame's last word has left.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt      <= '0;
            o_frames <= '0;
            state    <= STREAM;
        end else if (i_flush) begin
            cnt   <= '0;
            state <= STREAM;
        end else begin
            if (state == WAIT_DONE && i_frame_done) state <= STREAM;
            if (pop) begin
                if (o_last) begin
                    cnt      <= '0;
                    o_frames <= o_frames + 8'd1;
                    state    <= WAIT_DONE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dtw_sin_feeder.sv
// Randomised bench for dtw_sin_feeder against a queue-based frame model.
module tb_dtw_sin_feeder;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 32;

    logic             clk = 1'b0;
    logic             nrst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_last;
    logic             i_frame_done;
    logic             i_flush;
    logic [7:0]       o_frames;
`ifdef DTW_FEEDER_LEVEL_EN
    logic [3:0]       o_level;
`endif

    dtw_sin_feeder #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .i_frame_done (i_frame_done),
        .i_flush      (i_flush),
        .o_frames     (o_frames)
`ifdef DTW_FEEDER_LEVEL_EN
        ,
        .o_level      (o_level)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffered words, position within frame, waiting flag, frames delivered.
    logic [WIDTH-1:0] q[$];
    int               pos = 0;
    bit               waiting = 1'b0;
    logic [7:0]       m_frames = 8'd0;

    always @(posedge clk) begin
        bit m_push, m_pop, was_waiting;
        m_push      = i_valid && nrst && (q.size() < DEPTH);
        m_pop       = i_ready && nrst && !waiting && (q.size() > 0);
        was_waiting = waiting;
        if (!nrst) begin
            q.delete();
            pos      = 0;
            waiting  = 1'b0;
            m_frames = 8'd0;
        end else if (i_flush) begin
            q.delete();
            pos     = 0;
            waiting = 1'b0;
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(i_data);
            if (was_waiting && i_frame_done) waiting = 1'b0;
            if (m_pop) begin
                if (pos == FRAME_LEN - 1) begin
                    pos      = 0;
                    m_frames = m_frames + 8'd1;
                    waiting  = 1'b1;
                end else begin
                    pos++;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_rdy, e_vld, e_last;
        if (chk_en) begin
            e_rdy  = nrst && (q.size() < DEPTH);
            e_vld  = nrst && !waiting && (q.size() > 0);
            e_last = e_vld && (pos == FRAME_LEN - 1);
            chk("o_ready", 32'(o_ready), 32'(e_rdy));
            chk("o_valid", 32'(o_valid), 32'(e_vld));
            chk("o_last", 32'(o_last), 32'(e_last));
            chk("o_frames", 32'(o_frames), 32'(m_frames));
            if (e_vld) chk("o_data", o_data, q[0]);
`ifdef DTW_FEEDER_LEVEL_EN
            chk("o_level", 32'(o_level), 32'(q.size()));
`endif
        end
    end

    bit acc;
    bit popd;
    int pops    = 0;
    int last_at = 0;

    task automatic tick();
        #1;
        acc  = i_valid && o_ready;
        popd = o_valid && i_ready;
        if (popd) begin
            pops++;
            if (o_last) last_at = pops;
        end
        @(posedge clk);
        #1;
        if (acc) i_data = $urandom;
    endtask

    initial begin
        nrst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
        i_frame_done = 1'b0; i_flush = 1'b0;

        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_o_ready", 32'(o_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_frames", 32'(o_frames), 32'd0);
        nrst = 1'b1;
        #1;
        chk("release_o_ready", 32'(o_ready), 32'd1);

        // Fill to full with the core stalled, then offer one word too many.
        i_valid = 1'b1; i_data = $urandom;
        repeat (8) tick();
        chk("full_o_ready", 32'(o_ready), 32'd0);
        i_data = 32'hDEAD_BEEF;
        repeat (2) tick();
        chk("full_hold_o_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b0; i_ready = 1'b1; pops = 0;
        repeat (10) tick();
        chk("drain_pops", 32'(pops), 32'd8);
        i_flush = 1'b1; tick(); i_flush = 1'b0;

        // One full frame back to back.
        pops = 0; last_at = 0;
        i_valid = 1'b1; i_data = $urandom;
        repeat (45) tick();
        chk("frame1_last_at", 32'(last_at), 32'd32);
        chk("frame1_pops", 32'(pops), 32'd32);
        chk("frame1_o_frames", 32'(o_frames), 32'd1);
        chk("frame1_wait_o_valid", 32'(o_valid), 32'd0);

        // Done pulses mid-frame and on the last pop must both be ignored.
        i_frame_done = 1'b1; tick(); i_frame_done = 1'b0;
        pops = 0; last_at = 0;
        for (int k = 0; k < 45; k++) begin
            i_frame_done = (k == 4) || o_last;
            tick();
        end
        i_frame_done = 1'b0;
        repeat (3) tick();
        chk("gate_last_at", 32'(last_at), 32'd32);
        chk("gate_o_frames", 32'(o_frames), 32'd2);
        chk("gate_still_waiting", 32'(o_valid), 32'd0);
        i_frame_done = 1'b1; tick(); i_frame_done = 1'b0;
        chk("gate_resume_o_valid", 32'(o_valid), 32'd1);

        // Simultaneous push/pop at full and at one entry.
        i_valid = 1'b1; i_ready = 1'b1;
        repeat (6) tick();
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        i_ready = 1'b0; tick();
        i_ready = 1'b1;
        repeat (6) tick();
        i_valid = 1'b0;
        repeat (2) tick();
        i_flush = 1'b1; tick(); i_flush = 1'b0;

        // Flush mid-frame: 10 pops with 4 words buffered.
        pops = 0; i_ready = 1'b0; i_valid = 1'b1;
        repeat (8) tick();
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (4) tick();
        i_valid = 1'b1;
        repeat (6) tick();
        chk("preflush_pops", 32'(pops), 32'd10);
        i_flush = 1'b1; tick(); i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_o_valid", 32'(o_valid), 32'd0);
        chk("flush_o_frames", 32'(o_frames), 32'd2);
        pops = 0; last_at = 0; i_valid = 1'b1;
        repeat (45) tick();
        chk("postflush_last_at", 32'(last_at), 32'd32);
        chk("postflush_o_frames", 32'(o_frames), 32'd3);
        i_frame_done = 1'b1; tick(); i_frame_done = 1'b0;

        // Random traffic with occasional done pulses, flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            i_valid      = ($urandom_range(0, 3) != 0);
            i_ready      = ($urandom_range(0, 3) != 0);
            i_frame_done = ($urandom_range(0, 7) == 0);
            i_flush      = ($urandom_range(0, 199) == 0);
            nrst         = ($urandom_range(0, 499) != 0);
            tick();
        end
        nrst = 1'b1; i_flush = 1'b0; i_frame_done = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
